// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
// Holds the state encodings, grant index type and bus-width defaults.
package mem_bus_arbiter_pkg;

  localparam int unsigned ADDRESS_INDEX_LIMIT = 25;
  localparam int unsigned DATA_INDEX_LIMIT    = 31;
  localparam int unsigned ADDR_W_DEF          = ADDRESS_INDEX_LIMIT + 1;
  localparam int unsigned DATA_W_DEF          = DATA_INDEX_LIMIT + 1;
  localparam int unsigned MEM_LATENCY_DEF     = 2;
  localparam int unsigned CNT_W               = 4;

  typedef enum logic [1:0] {
    MEM_ARB_ST_IDLE   = 2'd0,
    MEM_ARB_ST_ACCESS = 2'd1,
    MEM_ARB_ST_DONE   = 2'd2
  } arbState_e;

  typedef enum logic {
    GRANT_M0 = 1'b0,
    GRANT_M1 = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way request picker for the memory bus arbiter.
// MEM_ARB_FIXED_PRIO_EN: M1 wins every tie; otherwise ties alternate via lastGrant.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic   req0_i,
  input  logic   req1_i,
  input  grant_e lastGrant_i,
  output logic   valid_o,
  output grant_e idx_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unusedLastGrant;
  assign unusedLastGrant = lastGrant_i;
`endif

  always_comb begin
    valid_o = req0_i | req1_i;
    idx_o   = GRANT_M0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    if (req1_i) idx_o = GRANT_M1;
`else
    // A tie goes to whichever master was not served last.
    if (req0_i && req1_i) begin
      idx_o = (lastGrant_i == GRANT_M0) ? GRANT_M1 : GRANT_M0;
    end else if (req1_i) begin
      idx_o = GRANT_M1;
    end
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the processor (M0) and the loader/DMA (M1).
// Build option MEM_ARB_FIXED_PRIO_EN selects fixed M1 priority instead of round-robin.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0Req_i,
  input  logic              m0Read_i,
  input  logic              m0Write_i,
  input  logic [ADDR_W-1:0] m0Addr_i,
  input  logic [DATA_W-1:0] m0Wdata_i,
  output logic [DATA_W-1:0] m0Rdata_o,
  output logic              m0Ack_o,
  input  logic              m1Req_i,
  input  logic              m1Read_i,
  input  logic              m1Write_i,
  input  logic [ADDR_W-1:0] m1Addr_i,
  input  logic [DATA_W-1:0] m1Wdata_i,
  output logic [DATA_W-1:0] m1Rdata_o,
  output logic              m1Ack_o,
  output logic              memRead_o,
  output logic              memWrite_o,
  output logic [ADDR_W-1:0] memAddr_o,
  output logic [DATA_W-1:0] memWdata_o,
  input  logic [DATA_W-1:0] memRdata_i,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arbState_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  grant_e            lastGrant_q, lastGrant_d;
  grant_e            winner_q, winner_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              pickValid;
  grant_e            pickIdx;
  logic              selRead;
  logic              selWrite;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  mem_arb_pick uPick (
    .req0_i      (m0Req_i),
    .req1_i      (m1Req_i),
    .lastGrant_i (lastGrant_q),
    .valid_o     (pickValid),
    .idx_o       (pickIdx)
  );

  assign selRead  = (pickIdx == GRANT_M1) ? m1Read_i  : m0Read_i;
  assign selWrite = (pickIdx == GRANT_M1) ? m1Write_i : m0Write_i;
  assign selAddr  = (pickIdx == GRANT_M1) ? m1Addr_i  : m0Addr_i;
  assign selWdata = (pickIdx == GRANT_M1) ? m1Wdata_i : m0Wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= MEM_ARB_ST_IDLE;
      cnt_q       <= '0;
      lastGrant_q <= GRANT_M1;
      winner_q    <= GRANT_M0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastGrant_q <= lastGrant_d;
      winner_q    <= winner_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lastGrant_d = lastGrant_q;
    winner_d    = winner_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    m0Rdata_o   = '0;
    m0Ack_o     = 1'b0;
    m1Rdata_o   = '0;
    m1Ack_o     = 1'b0;
    memRead_o   = 1'b0;
    memWrite_o  = 1'b0;
    memAddr_o   = '0;
    memWdata_o  = '0;
    busy_o      = 1'b0;

    unique case (state_q)
      MEM_ARB_ST_IDLE: begin
        if (pickValid) begin
          winner_d    = pickIdx;
          lastGrant_d = pickIdx;
          // READ==WRITE is granted but latched as "no strobe".
          rd_d        = selRead & ~selWrite;
          wr_d        = selWrite & ~selRead;
          addr_d      = selAddr;
          wdata_d     = selWdata;
          cnt_d       = CNT_LOAD;
          state_d     = MEM_ARB_ST_ACCESS;
        end
      end
      MEM_ARB_ST_ACCESS: begin
        busy_o     = 1'b1;
        memRead_o  = rd_q;
        memWrite_o = wr_q;
        memAddr_o  = addr_q;
        memWdata_o = wdata_q;
        if (cnt_q == '0) begin
          rdata_d = rd_q ? memRdata_i : '0;
          state_d = MEM_ARB_ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MEM_ARB_ST_DONE: begin
        busy_o = 1'b1;
        if (winner_q == GRANT_M1) begin
          m1Ack_o   = 1'b1;
          m1Rdata_o = rdata_q;
        end else begin
          m0Ack_o   = 1'b1;
          m0Rdata_o = rdata_q;
        end
        state_d = MEM_ARB_ST_IDLE;
      end
      default: state_d = MEM_ARB_ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances (latency 2, 1, 15) checked every cycle
// against a timeline model of grants, strobes and acknowledges.
module tb_mem_bus_arbiter;

  localparam int NDUT = 3;
  localparam int AW   = 26;
  localparam int DW   = 32;

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic          m0Req[NDUT], m0Read[NDUT], m0Write[NDUT], m0Ack[NDUT];
  logic [AW-1:0] m0Addr[NDUT];
  logic [DW-1:0] m0Wdata[NDUT], m0Rdata[NDUT];
  logic          m1Req[NDUT], m1Read[NDUT], m1Write[NDUT], m1Ack[NDUT];
  logic [AW-1:0] m1Addr[NDUT];
  logic [DW-1:0] m1Wdata[NDUT], m1Rdata[NDUT];
  logic          memRead[NDUT], memWrite[NDUT], busy[NDUT];
  logic [AW-1:0] memAddr[NDUT];
  logic [DW-1:0] memWdata[NDUT], memRdata[NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(latOf(g))) dut (
      .clk_i(clk), .rst_i(rst),
      .m0Req_i(m0Req[g]), .m0Read_i(m0Read[g]), .m0Write_i(m0Write[g]),
      .m0Addr_i(m0Addr[g]), .m0Wdata_i(m0Wdata[g]), .m0Rdata_o(m0Rdata[g]), .m0Ack_o(m0Ack[g]),
      .m1Req_i(m1Req[g]), .m1Read_i(m1Read[g]), .m1Write_i(m1Write[g]),
      .m1Addr_i(m1Addr[g]), .m1Wdata_i(m1Wdata[g]), .m1Rdata_o(m1Rdata[g]), .m1Ack_o(m1Ack[g]),
      .memRead_o(memRead[g]), .memWrite_o(memWrite[g]), .memAddr_o(memAddr[g]),
      .memWdata_o(memWdata[g]), .memRdata_i(memRdata[g]), .busy_o(busy[g])
    );
  end

  // Timeline model: a grant at cycle g gives strobes in g+1..g+L and the ack at g+L+1.
  int            cyc = 0;
  bit            mActive[NDUT];
  int            mGnt[NDUT];
  int            mWin[NDUT];
  int            mLast[NDUT];
  bit            mFresh[NDUT];
  bit            mRd[NDUT], mWr[NDUT];
  logic [AW-1:0] mAddr[NDUT];
  logic [DW-1:0] mWd[NDUT], mCap[NDUT];
  bit            memRandom = 1'b0;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, observed, expected);
    else
      passCount++;
  endtask

  function automatic int phaseOf(input int d);
    if (!mActive[d]) return 0;
    if (cyc >= mGnt[d] + 1 && cyc <= mGnt[d] + latOf(d)) return 1;
    if (cyc == mGnt[d] + latOf(d) + 1) return 2;
    return 0;
  endfunction

  task automatic checkAll();
    for (int d = 0; d < NDUT; d++) begin
      bit acc, dn;
      acc = (phaseOf(d) == 1);
      dn  = (phaseOf(d) == 2);
      checkOutput($sformatf("busy[%0d]", d), 64'(busy[d]), 64'(acc || dn));
      checkOutput($sformatf("memRead[%0d]", d), 64'(memRead[d]), 64'(acc && mRd[d]));
      checkOutput($sformatf("memWrite[%0d]", d), 64'(memWrite[d]), 64'(acc && mWr[d]));
      if (acc) begin
        checkOutput($sformatf("memAddr[%0d]", d), 64'(memAddr[d]), 64'(mAddr[d]));
        checkOutput($sformatf("memWdata[%0d]", d), 64'(memWdata[d]), 64'(mWd[d]));
      end
      if (mFresh[d]) begin
        checkOutput($sformatf("rstAddr[%0d]", d), 64'(memAddr[d]), 64'd0);
        checkOutput($sformatf("rstWdata[%0d]", d), 64'(memWdata[d]), 64'd0);
      end
      checkOutput($sformatf("m0Ack[%0d]", d), 64'(m0Ack[d]), 64'(dn && mWin[d] == 0));
      checkOutput($sformatf("m1Ack[%0d]", d), 64'(m1Ack[d]), 64'(dn && mWin[d] == 1));
      checkOutput($sformatf("m0Rdata[%0d]", d), 64'(m0Rdata[d]), (dn && mWin[d] == 0) ? 64'(mCap[d]) : 64'd0);
      checkOutput($sformatf("m1Rdata[%0d]", d), 64'(m1Rdata[d]), (dn && mWin[d] == 1) ? 64'(mCap[d]) : 64'd0);
    end
  endtask

  task automatic modelUpdate();
    for (int d = 0; d < NDUT; d++) begin
      int l;
      l = latOf(d);
      if (rst) begin
        mActive[d] = 1'b0;
        mLast[d]   = 1;
        mFresh[d]  = 1'b1;
      end else begin
        mFresh[d] = 1'b0;
        if (mActive[d] && cyc == mGnt[d] + l) mCap[d] = mRd[d] ? memRdata[d] : '0;
        if (mActive[d] && cyc >= mGnt[d] + l + 2) mActive[d] = 1'b0;
        if (!mActive[d] && (m0Req[d] || m1Req[d])) begin
          int w;
`ifdef MEM_ARB_FIXED_PRIO_EN
          w = m1Req[d] ? 1 : 0;
`else
          w = (m0Req[d] && m1Req[d]) ? 1 - mLast[d] : (m1Req[d] ? 1 : 0);
`endif
          mLast[d]   = w;
          mWin[d]    = w;
          mRd[d]     = (w == 1) ? (m1Read[d] && !m1Write[d]) : (m0Read[d] && !m0Write[d]);
          mWr[d]     = (w == 1) ? (m1Write[d] && !m1Read[d]) : (m0Write[d] && !m0Read[d]);
          mAddr[d]   = (w == 1) ? m1Addr[d] : m0Addr[d];
          mWd[d]     = (w == 1) ? m1Wdata[d] : m0Wdata[d];
          mGnt[d]    = cyc;
          mActive[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    if (memRandom)
      for (int d = 0; d < NDUT; d++) memRdata[d] = $urandom;
    modelUpdate();
    @(posedge clk);
    #1;
    cyc++;
    checkAll();
  endtask

  task automatic setMaster(input int d, input int m, input logic req, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (m == 0) begin
      m0Req[d] = req; m0Read[d] = rd; m0Write[d] = wr; m0Addr[d] = a; m0Wdata[d] = wd;
    end else begin
      m1Req[d] = req; m1Read[d] = rd; m1Write[d] = wr; m1Addr[d] = a; m1Wdata[d] = wd;
    end
  endtask

  task automatic randomRequest(input int d, input int m);
    int c;
    c = $urandom_range(0, 7);
    setMaster(d, m, 1'b1, (c == 1) || (c >= 2 && c <= 4), (c == 1) || (c >= 5),
              AW'($urandom), $urandom);
  endtask

  function automatic logic reqOf(input int d, input int m);
    return (m == 0) ? m0Req[d] : m1Req[d];
  endfunction

  task automatic applyStimulus();
    for (int d = 0; d < NDUT; d++) begin
      for (int m = 0; m < 2; m++) begin
        bit mine;
        mine = mActive[d] && mWin[d] == m && phaseOf(d) != 0;
        if (reqOf(d, m)) begin
          if (mine && phaseOf(d) == 2) begin
            if ($urandom_range(0, 1) == 1) setMaster(d, m, 1'b0, 1'b0, 1'b0, '0, '0);
            else randomRequest(d, m);
          end else if (mine && $urandom_range(0, 2) == 0) begin
            randomRequest(d, m);
          end
        end else if ($urandom_range(0, 9) < 4) begin
          randomRequest(d, m);
        end
      end
    end
  endtask

  task automatic clearMasters();
    for (int d = 0; d < NDUT; d++) begin
      setMaster(d, 0, 1'b0, 1'b0, 1'b0, '0, '0);
      setMaster(d, 1, 1'b0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // One request on every instance; measures ack latency, strobe width and returned data.
  task automatic runDirected(input string tag, input int m, input logic rd, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [DW-1:0] memData);
    int            ackC[NDUT];
    int            strobes[NDUT];
    logic [DW-1:0] ackD[NDUT];
    int            t;
    bit            allDone;
    memRandom = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      setMaster(d, m, 1'b1, rd, wr, a, wd);
      memRdata[d] = memData;
      ackC[d]     = -1;
      strobes[d]  = 0;
      ackD[d]     = '0;
    end
    t = cyc;
    allDone = 1'b0;
    for (int i = 0; i < 40 && !allDone; i++) begin
      cycle();
      allDone = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
        if (ackC[d] < 0) begin
          strobes[d] += int'(memRead[d]) + int'(memWrite[d]);
          if ((m == 0) ? m0Ack[d] : m1Ack[d]) begin
            ackC[d] = cyc;
            ackD[d] = (m == 0) ? m0Rdata[d] : m1Rdata[d];
            setMaster(d, m, 1'b0, 1'b0, 1'b0, '0, '0);
          end else begin
            allDone = 1'b0;
          end
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("%s.ackLatency[%0d]", tag, d), 64'(ackC[d] - t), 64'(latOf(d) + 1));
      checkOutput($sformatf("%s.strobeWidth[%0d]", tag, d), 64'(strobes[d]), (rd != wr) ? 64'(latOf(d)) : 64'd0);
      checkOutput($sformatf("%s.ackData[%0d]", tag, d), 64'(ackD[d]), (rd && !wr) ? 64'(memData) : 64'd0);
    end
    cycle();
  endtask

  initial begin
    int wins[NDUT][4];
    int nw[NDUT];
    bit more;

    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      mActive[d] = 1'b0; mLast[d] = 1; mFresh[d] = 1'b0; mWin[d] = 0; mGnt[d] = 0;
      mRd[d] = 1'b0; mWr[d] = 1'b0; mAddr[d] = '0; mWd[d] = '0; mCap[d] = '0;
      memRdata[d] = '0;
    end
    clearMasters();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    runDirected("m0Read", 0, 1'b1, 1'b0, 26'h0000010, 32'h0, 32'hDEADBEEF);
    runDirected("m1Write", 1, 1'b0, 1'b1, 26'h3FFFFFF, 32'h12345678, 32'hA5A5A5A5);
    runDirected("illegalCmd", 0, 1'b1, 1'b1, 26'h0000123, 32'hCAFEF00D, 32'h5A5A5A5A);

    // Both masters requesting straight out of reset: grant order observed via acks.
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      setMaster(d, 0, 1'b1, 1'b1, 1'b0, 26'h0000040, '0);
      setMaster(d, 1, 1'b1, 1'b1, 1'b0, 26'h0000080, '0);
      nw[d] = 0;
      for (int k = 0; k < 4; k++) wins[d][k] = -1;
    end
    memRandom = 1'b1;
    cycle();
    rst = 1'b0;
    more = 1'b1;
    for (int i = 0; i < 200 && more; i++) begin
      cycle();
      more = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
        if (nw[d] < 4) begin
          if (m0Ack[d]) begin wins[d][nw[d]] = 0; nw[d]++; end
          else if (m1Ack[d]) begin wins[d][nw[d]] = 1; nw[d]++; end
        end
        if (nw[d] < 4) more = 1'b1;
      end
    end
    for (int d = 0; d < NDUT; d++)
      for (int k = 0; k < 4; k++)
`ifdef MEM_ARB_FIXED_PRIO_EN
        checkOutput($sformatf("tieOrder[%0d][%0d]", d, k), 64'(wins[d][k]), 64'd1);
`else
        checkOutput($sformatf("tieOrder[%0d][%0d]", d, k), 64'(wins[d][k]), 64'(k % 2));
`endif
    clearMasters();
    repeat (20) cycle();

    // Reset in the second access cycle of an M0 read on the latency-2 instance.
    for (int d = 0; d < NDUT; d++) setMaster(d, 0, 1'b1, 1'b1, 1'b0, 26'h0000055, '0);
    cycle();
    cycle();
    checkOutput("preRstRead", 64'(memRead[0]), 64'd1);
    rst = 1'b1;
    clearMasters();
    cycle();
    checkOutput("postRstRead", 64'(memRead[0]), 64'd0);
    checkOutput("postRstBusy", 64'(busy[0]), 64'd0);
    checkOutput("postRstAck", 64'(m0Ack[0]), 64'd0);
    rst = 1'b0;
    cycle();
    runDirected("reRequest", 0, 1'b1, 1'b0, 26'h0000055, '0, 32'h0BADF00D);

    memRandom = 1'b1;
    repeat (500) begin
      applyStimulus();
      cycle();
    end
    clearMasters();
    repeat (20) cycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
